multicycle_control_unit: RTL and testbench
==========================================

Name: multicycle_control_unit

Overview:
Multi-cycle successor to the single-cycle RV32I control unit. An FSM sequences each instruction through fetch, decode, execute, memory and writeback, driving datapath strobes that the single-cycle design held static. It adds a variable-latency memory handshake, an optional M-extension handshake, a memory watchdog, misalignment and illegal-instruction traps, and a retired-instruction counter. It sits between the instruction register/ALU flag and the shared datapath; all select and op encodings come from the ALUInstr, InstrTypes and Instructions packages.

Parameters:
TIMEOUT_CYCLES, 16, maximum mem_req cycles without mem_ready before a bus trap; 0 disables the watchdog
M_EXT, 0, 1 enables funct7=0000001 R-type dispatch to the mul/div unit; 0 makes those instructions illegal
CNT_W, 32, width of instret

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
instr  in  32  IR contents, stable from DECODE onward
alu_flag  in  1  ALU compare result, 1 = comparison true
addr_lo  in  2  ALU result bits [1:0] (effective address)
mem_ready  in  1  memory completes the access this cycle
md_done  in  1  mul/div result valid, 1-cycle pulse
mem_req  out  1  memory access request
mem_we  out  1  1 = store
mem_addr_sel  out  1  0 = PC, 1 = ALU result
mem_size  out  4  MEM_* size/sign code
ir_write  out  1  latch fetched word into IR
pc_write  out  1  update PC
pc_sel  out  2  PC_PLUS4 / PC_IMM / PC_ALU
reg_write  out  1  register file write enable
wb_sel  out  2  WB_ALU / WB_DATA_MEM / WB_PC / WB_IMM
alu_op  out  4  ALUInstr code
alu_a_sel  out  1  AMUX1_REG / AMUX1_PC
alu_b_sel  out  1  AMUX2_REG / AMUX2_IMM
md_start  out  1  mul/div start pulse
retire  out  1  instruction retired this cycle
trap  out  1  sticky halt indicator
trap_cause  out  2  0 none, 1 illegal, 2 bus timeout, 3 misaligned
instret  out  CNT_W  retired-instruction count, wraps

Behaviour:
- States: IDLE, FETCH, DECODE, EXEC, MDWAIT, MEM, WB, TRAP.
- Reset: state IDLE. All strobes 0, trap=0, trap_cause=0, instret=0, watchdog counter 0. Reset during any state aborts the instruction immediately. IDLE goes to FETCH on the next cycle.
- Outputs are combinational from state and instr. Non-strobe selects read 0 in states where they are unused.
- FETCH: mem_req=1, mem_addr_sel=0, mem_size=word.
  - The access completes on the clock edge where mem_req and mem_ready are both 1; ir_write=1 in that cycle; next state DECODE.
  - Zero-wait memory may assert mem_ready in the first request cycle.
- DECODE (1 cycle): an unsupported opcode, funct3 or funct7, a shift imm[11:5] other than 0 or 0100000, or a mul/div with M_EXT=0 goes to TRAP with cause 1. Otherwise next state EXEC.
- EXEC: drive alu_op and selects per instruction class.
  - ALU/LUI/AUIPC/JAL/JALR: next state WB.
  - Load/store: go to MEM when aligned. Misaligned means halfword with addr_lo[0]=1, or word with addr_lo≠0; it goes to TRAP with cause 3 and mem_req is never raised.
  - Branch: alu_op is EQ for BEQ/BNE, SLT for BLT/BGE, ULT for BLTU/BGEU.
    - taken = alu_flag XOR funct3[0].
    - pc_write=1, pc_sel = PC_IMM if taken else PC_PLUS4, retire=1, next state FETCH.
  - Mul/div: md_start=1 for one cycle, next state MDWAIT.
- MDWAIT: hold alu selects and wait for md_done, then go to WB. No timeout applies.
- MEM: mem_req=1, mem_addr_sel=1, mem_we=1 for stores; mem_size is decoded from funct3. On mem_ready:
  - Load: go to WB.
  - Store: pc_write=1 (PC_PLUS4), retire=1, next state FETCH.
- WB (1 cycle):
  - reg_write=1 with wb_sel per class.
  - pc_write=1 with pc_sel: PC_ALU for JALR, PC_IMM for JAL, PC_PLUS4 otherwise.
  - retire=1, next state FETCH.
- Watchdog: counts consecutive cycles of mem_req=1 with mem_ready=0 and clears on completion or on leaving the state. When the count reaches TIMEOUT_CYCLES (TIMEOUT_CYCLES>0), next state is TRAP with cause 2.
- TRAP: absorbing until rst. trap=1, trap_cause latched, all strobes 0, instret frozen.
- instret increments on every retire and wraps from all-ones to 0.
- Latency with zero-wait memory: branch 3 cycles, ALU/jump/store 4, load 5, mul/div 4 + md_done delay.

Test Plan:
- ADD x3,x1,x2 (0x002081B3), mem_ready=1 always → FETCH, DECODE, EXEC, WB; reg_write=1, wb_sel=WB_ALU and retire=1 in cycle 4 only; instret=1.
- BNE x1,x2,+8 (0x00209463) with alu_flag=1 → pc_sel=PC_PLUS4, 3-cycle retire. Repeat with alu_flag=0 → pc_sel=PC_IMM.
- LW x2,0(x1) (0x0000A103), addr_lo=0, mem_ready low 3 cycles in MEM → mem_req held 4 cycles; wb_sel=WB_DATA_MEM; retire after 8 cycles total. Same with addr_lo=2 → trap=1, trap_cause=3, no mem_req in MEM.
- TIMEOUT_CYCLES=8, mem_ready stuck 0 in FETCH → TRAP entered after 8 request cycles, trap_cause=2, outputs quiet for 20 further cycles.
- M_EXT=1, MUL (0x022081B3), md_done 5 cycles after md_start → single md_start pulse, reg_write one cycle after md_done. With M_EXT=0 → trap_cause=1 after DECODE.
- rst asserted mid-MEM of a store → mem_req and mem_we drop asynchronously; instret=0; FETCH resumes 1 cycle after release.

Source files
------------

// File: rtl/multicycle_control_unit.sv
// Multi-cycle RV32I control FSM: sequences fetch/decode/execute/memory/writeback,
// with memory watchdog, misalignment and illegal-instruction traps and an instret counter.
module multicycle_control_unit #(
    parameter int TIMEOUT_CYCLES = 16,
    parameter bit M_EXT          = 1'b0,
    parameter int CNT_W          = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      instr,
    input  logic             alu_flag,
    input  logic [1:0]       addr_lo,
    input  logic             mem_ready,
    input  logic             md_done,
    output logic             mem_req,
    output logic             mem_we,
    output logic             mem_addr_sel,
    output logic [3:0]       mem_size,
    output logic             ir_write,
    output logic             pc_write,
    output logic [1:0]       pc_sel,
    output logic             reg_write,
    output logic [1:0]       wb_sel,
    output logic [3:0]       alu_op,
    output logic             alu_a_sel,
    output logic             alu_b_sel,
    output logic             md_start,
    output logic             retire,
    output logic             trap,
    output logic [1:0]       trap_cause,
    output logic [CNT_W-1:0] instret
);
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    localparam logic [1:0] PC_PLUS4 = 2'd0, PC_IMM = 2'd1, PC_ALU = 2'd2;
    localparam logic [1:0] WB_ALU = 2'd0, WB_DATA_MEM = 2'd1, WB_PC = 2'd2, WB_IMM = 2'd3;
    localparam logic AMUX1_REG = 1'b0, AMUX1_PC = 1'b1;
    localparam logic AMUX2_REG = 1'b0, AMUX2_IMM = 1'b1;
    localparam logic [3:0] ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_SLL = 4'd2, ALU_SLT = 4'd3,
                           ALU_ULT = 4'd4, ALU_XOR = 4'd5, ALU_SRL = 4'd6, ALU_SRA = 4'd7,
                           ALU_OR  = 4'd8, ALU_AND = 4'd9, ALU_EQ  = 4'd10;
    localparam logic [3:0] MEM_W = 4'b0010;
    localparam logic [1:0] CAUSE_ILLEGAL = 2'd1, CAUSE_BUS = 2'd2, CAUSE_MISALIGN = 2'd3;

    localparam int WD_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [WD_W-1:0] WD_LAST = WD_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    typedef enum logic [2:0] {IDLE, FETCH, DECODE, EXEC, MDWAIT, MEM, WB, TRAP} state_t;

    state_t          state, state_next;
    logic [1:0]      cause_q, cause_next;
    logic [WD_W-1:0] wd_cnt;
    logic            wd_expire;

    logic [6:0] opcode, funct7;
    logic [2:0] funct3;
    logic       legal, misaligned;
    logic       is_alu, is_imm, is_load, is_store, is_branch;
    logic       is_lui, is_auipc, is_jal, is_jalr, is_md;
    logic [3:0] alu_op_dec;
    logic       a_sel_dec, b_sel_dec;
    logic       unused_bits;

    assign opcode      = instr[6:0];
    assign funct3      = instr[14:12];
    assign funct7      = instr[31:25];
    assign unused_bits = ^{instr[24:15], instr[11:7]};

    function automatic logic [3:0] alu_fn(input logic [2:0] f3, input logic alt);
        case (f3)
            3'b000:  alu_fn = alt ? ALU_SUB : ALU_ADD;
            3'b001:  alu_fn = ALU_SLL;
            3'b010:  alu_fn = ALU_SLT;
            3'b011:  alu_fn = ALU_ULT;
            3'b100:  alu_fn = ALU_XOR;
            3'b101:  alu_fn = alt ? ALU_SRA : ALU_SRL;
            3'b110:  alu_fn = ALU_OR;
            default: alu_fn = ALU_AND;
        endcase
    endfunction

    always_comb begin
        legal = 1'b0;    is_alu = 1'b0;   is_imm = 1'b0;   is_load = 1'b0;
        is_store = 1'b0; is_branch = 1'b0; is_lui = 1'b0;  is_auipc = 1'b0;
        is_jal = 1'b0;   is_jalr = 1'b0;  is_md = 1'b0;
        case (opcode)
            OPC_OP: begin
                if (funct7 == 7'b0000000) begin
                    legal = 1'b1; is_alu = 1'b1;
                end else if (funct7 == 7'b0100000 && (funct3 == 3'b000 || funct3 == 3'b101)) begin
                    legal = 1'b1; is_alu = 1'b1;
                end else if (funct7 == 7'b0000001) begin
                    legal = M_EXT; is_md = 1'b1;
                end
            end
            OPC_OP_IMM: begin
                is_alu = 1'b1; is_imm = 1'b1;
                if (funct3 == 3'b001)      legal = (funct7 == 7'b0000000);
                else if (funct3 == 3'b101) legal = (funct7 == 7'b0000000) || (funct7 == 7'b0100000);
                else                       legal = 1'b1;
            end
            OPC_LOAD: begin
                is_load = 1'b1;
                legal   = (funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
            end
            OPC_STORE: begin
                is_store = 1'b1;
                legal    = (funct3 inside {3'b000, 3'b001, 3'b010});
            end
            OPC_BRANCH: begin
                is_branch = 1'b1;
                legal     = (funct3 != 3'b010) && (funct3 != 3'b011);
            end
            OPC_LUI:   begin is_lui = 1'b1;   legal = 1'b1; end
            OPC_AUIPC: begin is_auipc = 1'b1; legal = 1'b1; end
            OPC_JAL:   begin is_jal = 1'b1;   legal = 1'b1; end
            OPC_JALR:  begin is_jalr = 1'b1;  legal = (funct3 == 3'b000); end
            default: ;
        endcase
    end

    // funct7[5] selects SUB/SRA only for R-type, and for I-type only on the shift-right slot
    assign alu_op_dec = is_alu ? alu_fn(funct3, funct7[5] && (!is_imm || funct3 == 3'b101)) : ALU_ADD;
    assign a_sel_dec  = (is_auipc || is_jal) ? AMUX1_PC : AMUX1_REG;
    assign b_sel_dec  = (is_imm || is_load || is_store || is_lui || is_auipc || is_jal || is_jalr)
                        ? AMUX2_IMM : AMUX2_REG;
    assign misaligned = (funct3[1:0] == 2'b01 && addr_lo[0]) ||
                        (funct3[1:0] == 2'b10 && addr_lo != 2'b00);
    assign wd_expire  = (TIMEOUT_CYCLES > 0) && (wd_cnt == WD_LAST) && !mem_ready;

    always_comb begin
        state_next = state;    cause_next = cause_q;
        mem_req = 1'b0;        mem_we = 1'b0;      mem_addr_sel = 1'b0;  mem_size = 4'd0;
        ir_write = 1'b0;       pc_write = 1'b0;    pc_sel = PC_PLUS4;    reg_write = 1'b0;
        wb_sel = WB_ALU;       alu_op = ALU_ADD;   alu_a_sel = AMUX1_REG; alu_b_sel = AMUX2_REG;
        md_start = 1'b0;       retire = 1'b0;
        if (state inside {EXEC, MDWAIT, MEM, WB}) begin
            alu_op = alu_op_dec; alu_a_sel = a_sel_dec; alu_b_sel = b_sel_dec;
        end
        case (state)
            IDLE: state_next = FETCH;
            FETCH: begin
                mem_req  = 1'b1;
                mem_size = MEM_W;
                if (mem_ready) begin
                    ir_write = 1'b1; state_next = DECODE;
                end else if (wd_expire) begin
                    state_next = TRAP; cause_next = CAUSE_BUS;
                end
            end
            DECODE: begin
                if (!legal) begin
                    state_next = TRAP; cause_next = CAUSE_ILLEGAL;
                end else begin
                    state_next = EXEC;
                end
            end
            EXEC: begin
                if (is_branch) begin
                    case (funct3[2:1])
                        2'b00:   alu_op = ALU_EQ;
                        2'b10:   alu_op = ALU_SLT;
                        default: alu_op = ALU_ULT;
                    endcase
                    pc_write = 1'b1;
                    pc_sel   = (alu_flag ^ funct3[0]) ? PC_IMM : PC_PLUS4;
                    retire   = 1'b1;
                    state_next = FETCH;
                end else if (is_md) begin
                    md_start = 1'b1; state_next = MDWAIT;
                end else if (is_load || is_store) begin
                    if (misaligned) begin
                        state_next = TRAP; cause_next = CAUSE_MISALIGN;
                    end else begin
                        state_next = MEM;
                    end
                end else begin
                    state_next = WB;
                end
            end
            MDWAIT: if (md_done) state_next = WB;
            MEM: begin
                mem_req      = 1'b1;
                mem_addr_sel = 1'b1;
                mem_we       = is_store;
                mem_size     = {1'b0, funct3};
                if (mem_ready) begin
                    if (is_store) begin
                        pc_write = 1'b1; retire = 1'b1; state_next = FETCH;
                    end else begin
                        state_next = WB;
                    end
                end else if (wd_expire) begin
                    state_next = TRAP; cause_next = CAUSE_BUS;
                end
            end
            WB: begin
                reg_write = 1'b1;
                if (is_load)                wb_sel = WB_DATA_MEM;
                else if (is_jal || is_jalr) wb_sel = WB_PC;
                else if (is_lui)            wb_sel = WB_IMM;
                pc_write = 1'b1;
                if (is_jalr)     pc_sel = PC_ALU;
                else if (is_jal) pc_sel = PC_IMM;
                retire     = 1'b1;
                state_next = FETCH;
            end
            default: ;
        endcase
    end

    assign trap       = (state == TRAP);
    assign trap_cause = cause_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            cause_q <= 2'd0;
            instret <= '0;
            wd_cnt  <= '0;
        end else begin
            state   <= state_next;
            cause_q <= cause_next;
            if (retire) instret <= instret + 1'b1;
            wd_cnt  <= (mem_req && !mem_ready && state_next == state) ? wd_cnt + 1'b1 : '0;
        end
    end
endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed bench for multicycle_control_unit: two instances (M_EXT=1 with 8-cycle watchdog,
// M_EXT=0 with watchdog disabled and a 2-bit instret) share the same stimulus.
module tb_multicycle_control_unit;
    localparam logic [31:0] I_ADD      = 32'h002081B3;
    localparam logic [31:0] I_BNE      = 32'h00209463;
    localparam logic [31:0] I_LW       = 32'h0000A103;
    localparam logic [31:0] I_LH       = 32'h00009103;
    localparam logic [31:0] I_SW       = 32'h0020A023;
    localparam logic [31:0] I_MUL      = 32'h022081B3;
    localparam logic [31:0] I_JALR     = 32'h000100E7;
    localparam logic [31:0] I_SLLI_BAD = 32'h40109093;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] instr = 32'h0;
    logic        alu_flag = 1'b0;
    logic [1:0]  addr_lo = 2'b00;
    logic        mem_ready = 1'b0;
    logic        md_done = 1'b0;

    logic        mem_req, mem_we, mem_addr_sel, ir_write, pc_write, reg_write;
    logic        alu_a_sel, alu_b_sel, md_start, retire, trap;
    logic [3:0]  mem_size, alu_op;
    logic [1:0]  pc_sel, wb_sel, trap_cause;
    logic [31:0] instret;

    logic        mem_req_n, mem_we_n, mem_addr_sel_n, ir_write_n, pc_write_n, reg_write_n;
    logic        alu_a_sel_n, alu_b_sel_n, md_start_n, retire_n, trap_n;
    logic [3:0]  mem_size_n, alu_op_n;
    logic [1:0]  pc_sel_n, wb_sel_n, trap_cause_n;
    logic [1:0]  instret_n;

    int errors = 0;
    int checks = 0;

    multicycle_control_unit #(.TIMEOUT_CYCLES(8), .M_EXT(1'b1), .CNT_W(32)) dut (
        .clk(clk), .rst(rst), .instr(instr), .alu_flag(alu_flag), .addr_lo(addr_lo),
        .mem_ready(mem_ready), .md_done(md_done), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr_sel(mem_addr_sel), .mem_size(mem_size), .ir_write(ir_write),
        .pc_write(pc_write), .pc_sel(pc_sel), .reg_write(reg_write), .wb_sel(wb_sel),
        .alu_op(alu_op), .alu_a_sel(alu_a_sel), .alu_b_sel(alu_b_sel), .md_start(md_start),
        .retire(retire), .trap(trap), .trap_cause(trap_cause), .instret(instret)
    );

    multicycle_control_unit #(.TIMEOUT_CYCLES(0), .M_EXT(1'b0), .CNT_W(2)) dut_nm (
        .clk(clk), .rst(rst), .instr(instr), .alu_flag(alu_flag), .addr_lo(addr_lo),
        .mem_ready(mem_ready), .md_done(md_done), .mem_req(mem_req_n), .mem_we(mem_we_n),
        .mem_addr_sel(mem_addr_sel_n), .mem_size(mem_size_n), .ir_write(ir_write_n),
        .pc_write(pc_write_n), .pc_sel(pc_sel_n), .reg_write(reg_write_n), .wb_sel(wb_sel_n),
        .alu_op(alu_op_n), .alu_a_sel(alu_a_sel_n), .alu_b_sel(alu_b_sel_n),
        .md_start(md_start_n), .retire(retire_n), .trap(trap_n), .trap_cause(trap_cause_n),
        .instret(instret_n)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1; mem_ready = 1'b0; md_done = 1'b0; alu_flag = 1'b0; addr_lo = 2'b00;
        step(); step();
        check("rst_mem_req", 32'(mem_req), 0);
        check("rst_retire", 32'(retire), 0);
        check("rst_trap", 32'(trap), 0);
        check("rst_cause", 32'(trap_cause), 0);
        check("rst_instret", instret, 0);
        rst = 1'b0;
    endtask

    // Advances until retire is seen at a negedge (bounded); cyc counts from the first FETCH cycle.
    task automatic run_retire(input int max, output int cyc);
        cyc = 0;
        do begin
            step();
            cyc++;
        end while (!retire && cyc < max);
        check("retire_seen", 32'(retire), 1);
    endtask

    initial begin
        int cyc, req_cnt, ret_at, rw_at, st_at, start_cnt, start_n;
        logic [1:0] wbs;
        logic rw, quiet;

        // ADD: FETCH, DECODE, EXEC, WB
        instr = I_ADD;
        do_reset();
        mem_ready = 1'b1;
        step();
        check("add_fetch_req", 32'(mem_req), 1);
        check("add_fetch_irw", 32'(ir_write), 1);
        check("add_fetch_size", 32'(mem_size), 2);
        check("add_fetch_asel", 32'(mem_addr_sel), 0);
        step();
        check("add_dec_regw", 32'(reg_write), 0);
        check("add_dec_retire", 32'(retire), 0);
        step();
        check("add_exec_op", 32'(alu_op), 0);
        check("add_exec_bsel", 32'(alu_b_sel), 0);
        check("add_exec_retire", 32'(retire), 0);
        step();
        check("add_wb_regw", 32'(reg_write), 1);
        check("add_wb_sel", 32'(wb_sel), 0);
        check("add_wb_retire", 32'(retire), 1);
        check("add_wb_pcsel", 32'(pc_sel), 0);
        step();
        check("add_next_retire", 32'(retire), 0);
        check("add_instret", instret, 1);
        check("add_next_req", 32'(mem_req), 1);

        // BNE not taken, then taken; four retirements wrap the 2-bit counter
        instr = I_BNE;
        do_reset();
        mem_ready = 1'b1;
        alu_flag = 1'b1;
        run_retire(10, cyc);
        check("bne_nt_lat", 32'(cyc), 3);
        check("bne_nt_pcsel", 32'(pc_sel), 0);
        check("bne_nt_pcw", 32'(pc_write), 1);
        check("bne_nt_op", 32'(alu_op), 10);
        alu_flag = 1'b0;
        run_retire(10, cyc);
        check("bne_t_lat", 32'(cyc), 3);
        check("bne_t_pcsel", 32'(pc_sel), 1);
        run_retire(10, cyc);
        run_retire(10, cyc);
        step();
        check("bne_instret4", instret, 4);
        check("wrap_instret_n", 32'(instret_n), 0);

        // LW aligned, 3 wait cycles in MEM
        instr = I_LW;
        do_reset();
        req_cnt = 0; ret_at = 0; wbs = 2'd0; rw = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            step();
            mem_ready = !(c >= 4 && c <= 6);
            if (mem_req && mem_addr_sel) req_cnt++;
            if (c == 4) begin
                check("lw_mem_we", 32'(mem_we), 0);
                check("lw_mem_size", 32'(mem_size), 2);
            end
            if (retire && ret_at == 0) begin
                ret_at = c; wbs = wb_sel; rw = reg_write;
            end
        end
        check("lw_req_cycles", 32'(req_cnt), 4);
        check("lw_retire_at", 32'(ret_at), 8);
        check("lw_wb_sel", 32'(wbs), 1);
        check("lw_regw", 32'(rw), 1);

        // LW misaligned
        instr = I_LW;
        do_reset();
        mem_ready = 1'b1; addr_lo = 2'd2;
        req_cnt = 0;
        for (int c = 1; c <= 6; c++) begin
            step();
            if (mem_req && mem_addr_sel) req_cnt++;
        end
        check("mis_req_cycles", 32'(req_cnt), 0);
        check("mis_trap", 32'(trap), 1);
        check("mis_cause", 32'(trap_cause), 3);
        check("mis_instret", instret, 0);

        // LH at addr_lo=2 is aligned
        instr = I_LH;
        do_reset();
        mem_ready = 1'b1; addr_lo = 2'd2;
        run_retire(12, cyc);
        check("lh_lat", 32'(cyc), 5);
        check("lh_trap", 32'(trap), 0);

        // Watchdog: mem_ready stuck low in FETCH
        instr = I_ADD;
        do_reset();
        req_cnt = 0; quiet = 1'b0;
        for (int c = 1; c <= 28; c++) begin
            step();
            if (mem_req) req_cnt++;
            if (c == 9) begin
                check("wd_trap", 32'(trap), 1);
                check("wd_cause", 32'(trap_cause), 2);
            end
            if (c >= 9) quiet = quiet | mem_req | ir_write | pc_write | reg_write | retire | md_start | mem_we;
        end
        check("wd_req_cycles", 32'(req_cnt), 8);
        check("wd_quiet", 32'(quiet), 0);
        check("wd_instret", instret, 0);
        check("wd_off_trap_n", 32'(trap_n), 0);
        check("wd_off_req_n", 32'(mem_req_n), 1);

        // MUL: M_EXT=1 dispatches, M_EXT=0 traps illegal
        instr = I_MUL;
        do_reset();
        mem_ready = 1'b1;
        start_cnt = 0; start_n = 0; rw_at = 0; st_at = 0;
        for (int c = 1; c <= 10; c++) begin
            step();
            md_done = (c == 8);
            if (md_start) begin
                start_cnt++;
                if (st_at == 0) st_at = c;
            end
            if (md_start_n) start_n++;
            if (reg_write && rw_at == 0) rw_at = c;
            if (c == 3) begin
                check("mul_nm_trap", 32'(trap_n), 1);
                check("mul_nm_cause", 32'(trap_cause_n), 1);
            end
        end
        check("mul_start_cnt", 32'(start_cnt), 1);
        check("mul_start_at", 32'(st_at), 3);
        check("mul_regw_at", 32'(rw_at), 9);
        check("mul_nm_start", 32'(start_n), 0);
        check("mul_instret", instret, 1);

        // Shift immediate with imm[11:5]=0100000 on SLLI is illegal
        instr = I_SLLI_BAD;
        do_reset();
        mem_ready = 1'b1;
        step(); step(); step();
        check("slli_trap", 32'(trap), 1);
        check("slli_cause", 32'(trap_cause), 1);

        // JALR
        instr = I_JALR;
        do_reset();
        mem_ready = 1'b1;
        run_retire(10, cyc);
        check("jalr_lat", 32'(cyc), 4);
        check("jalr_pcsel", 32'(pc_sel), 2);
        check("jalr_wbsel", 32'(wb_sel), 2);
        check("jalr_regw", 32'(reg_write), 1);

        // Reset in the middle of a stalled store
        instr = I_ADD;
        do_reset();
        mem_ready = 1'b1;
        run_retire(10, cyc);
        instr = I_SW;
        step();
        step();
        step();
        mem_ready = 1'b0;
        step();
        check("sw_mem_req", 32'(mem_req), 1);
        check("sw_mem_we", 32'(mem_we), 1);
        check("sw_instret", instret, 1);
        step();
        #2 rst = 1'b1;
        #1;
        check("arst_mem_req", 32'(mem_req), 0);
        check("arst_mem_we", 32'(mem_we), 0);
        check("arst_instret", instret, 0);
        step();
        rst = 1'b0;
        check("rel_idle_req", 32'(mem_req), 0);
        step();
        check("rel_fetch_req", 32'(mem_req), 1);
        check("rel_fetch_asel", 32'(mem_addr_sel), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: got no completion expected finish before 100000");
        $fatal(1);
    end
endmodule
